secuenciador_mascara: RTL and testbench

//  Controller that sequences the mask-coefficient index used by the filter datapath.
//  - Holds the configured mask size N.
//  - On a start request, sweeps every coefficient position row-major: (fila,columna) from (0,0) to (N-1,N-1).
//  - Presents the linear index fila*N+columna with a valid/accept handshake.
//  - Sits between the filter's top-level control and the mask coefficient store / index stage.

---
 rtl/secuenciador_mascara.sv | 122 ++++++++++++
 tb/tb_secuenciador_mascara.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/secuenciador_mascara.sv
// Sweeps mask coefficient positions row-major and presents the linear index
// fila*N+columna through a valid/accept handshake.
module secuenciador_mascara #(
  parameter int BITS_MASCARA        = 4,
  parameter int BITS_INDICE_MASCARA = 10
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cargar_config,
  input  logic [BITS_MASCARA-1:0]        tamano_entrada,
  input  logic                           inicio,
  input  logic                           acepta,
  output logic [BITS_INDICE_MASCARA-1:0] indice_mascara,
  output logic [BITS_MASCARA-1:0]        fila,
  output logic [BITS_MASCARA-1:0]        columna,
  output logic                           valido,
  output logic                           ultimo,
  output logic                           ocupado,
  output logic                           fin,
  output logic                           error_config,
  output logic [BITS_MASCARA-1:0]        tamano_mascara
);

  typedef enum logic [1:0] {REPOSO, BARRIDO, FIN} estado_t;

  // Square is compared against 2^BITS_INDICE_MASCARA, which itself needs one extra bit.
  localparam int BITS_CUAD = (2*BITS_MASCARA > BITS_INDICE_MASCARA+1) ?
                             2*BITS_MASCARA : BITS_INDICE_MASCARA+1;
  localparam logic [BITS_CUAD-1:0]    LIMITE     = {{(BITS_CUAD-1){1'b0}}, 1'b1} << BITS_INDICE_MASCARA;
  localparam logic [BITS_MASCARA-1:0] UNO        = {{(BITS_MASCARA-1){1'b0}}, 1'b1};
  localparam logic [BITS_MASCARA-1:0] TAMANO_RST = BITS_MASCARA'(3);

  estado_t                          estado_q, estado_d;
  logic [BITS_MASCARA-1:0]          fila_q, fila_d;
  logic [BITS_MASCARA-1:0]          columna_q, columna_d;
  logic [BITS_INDICE_MASCARA-1:0]   indice_q, indice_d;
  logic [BITS_MASCARA-1:0]          tamano_q, tamano_d;
  logic                             error_q, error_d;

  logic [BITS_CUAD-1:0]    cuadrado;
  logic [BITS_MASCARA-1:0] n_menos_1;
  logic                    config_ok;
  logic                    transfer;

  assign cuadrado  = BITS_CUAD'(tamano_entrada) * BITS_CUAD'(tamano_entrada);
  assign config_ok = (tamano_entrada != '0) && (cuadrado <= LIMITE);
  assign n_menos_1 = tamano_q - UNO;

  assign valido         = (estado_q == BARRIDO);
  assign fin            = (estado_q == FIN);
  assign ocupado        = (estado_q != REPOSO);
  assign ultimo         = valido && (fila_q == n_menos_1) && (columna_q == n_menos_1);
  assign transfer       = valido && acepta;
  assign fila           = fila_q;
  assign columna        = columna_q;
  assign indice_mascara = indice_q;
  assign tamano_mascara = tamano_q;
  assign error_config   = error_q;

  always_comb begin
    estado_d  = estado_q;
    fila_d    = fila_q;
    columna_d = columna_q;
    indice_d  = indice_q;
    tamano_d  = tamano_q;
    error_d   = error_q;
    case (estado_q)
      REPOSO: begin
        // Configuration wins over a simultaneous start request.
        if (cargar_config) begin
          if (config_ok) begin
            tamano_d = tamano_entrada;
            error_d  = 1'b0;
          end else begin
            error_d  = 1'b1;
          end
        end else if (inicio) begin
          estado_d = BARRIDO;
        end
      end
      BARRIDO: begin
        if (transfer) begin
          if (ultimo) begin
            estado_d  = FIN;
            fila_d    = '0;
            columna_d = '0;
            indice_d  = '0;
          end else begin
            indice_d = indice_q + 1'b1;
            if (columna_q == n_menos_1) begin
              columna_d = '0;
              fila_d    = fila_q + UNO;
            end else begin
              columna_d = columna_q + UNO;
            end
          end
        end
      end
      FIN:     estado_d = REPOSO;
      default: estado_d = REPOSO;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q  <= REPOSO;
      fila_q    <= '0;
      columna_q <= '0;
      indice_q  <= '0;
      tamano_q  <= TAMANO_RST;
      error_q   <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      fila_q    <= fila_d;
      columna_q <= columna_d;
      indice_q  <= indice_d;
      tamano_q  <= tamano_d;
      error_q   <= error_d;
    end
  end

endmodule

// File: tb/tb_secuenciador_mascara.sv
// Directed bench for secuenciador_mascara with hand-computed expectations.
module tb_secuenciador_mascara;

  localparam int BM = 4;
  localparam int BI = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          cargar_config;
  logic [BM-1:0] tamano_entrada;
  logic          inicio;
  logic          acepta;
  logic [BI-1:0] indice_mascara;
  logic [BM-1:0] fila, columna, tamano_mascara;
  logic          valido, ultimo, ocupado, fin, error_config;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  secuenciador_mascara #(.BITS_MASCARA(BM), .BITS_INDICE_MASCARA(BI)) dut (
    .clk(clk), .reset(reset), .cargar_config(cargar_config),
    .tamano_entrada(tamano_entrada), .inicio(inicio), .acepta(acepta),
    .indice_mascara(indice_mascara), .fila(fila), .columna(columna),
    .valido(valido), .ultimo(ultimo), .ocupado(ocupado), .fin(fin),
    .error_config(error_config), .tamano_mascara(tamano_mascara)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reposo(input string tag);
    chk({tag, " valido"},  32'(valido),  0);
    chk({tag, " ocupado"}, 32'(ocupado), 0);
    chk({tag, " fin"},     32'(fin),     0);
    chk({tag, " indice"},  32'(indice_mascara), 0);
  endtask

  task automatic cargar(input int n);
    cargar_config  = 1'b1;
    tamano_entrada = BM'(n);
    tick();
    cargar_config  = 1'b0;
  endtask

  // Full sweep with acepta held high; checks every index, then FIN and return to REPOSO.
  task automatic barrido(input int n);
    inicio = 1'b1;
    acepta = 1'b1;
    tick();
    inicio = 1'b0;
    for (int i = 0; i < n*n; i++) begin
      chk($sformatf("n%0d idx%0d indice", n, i), 32'(indice_mascara), i);
      chk($sformatf("n%0d idx%0d fila", n, i),   32'(fila),    i / n);
      chk($sformatf("n%0d idx%0d col", n, i),    32'(columna), i % n);
      chk($sformatf("n%0d idx%0d valido", n, i), 32'(valido),  1);
      chk($sformatf("n%0d idx%0d ultimo", n, i), 32'(ultimo),  (i == n*n-1) ? 1 : 0);
      tick();
    end
    chk($sformatf("n%0d fin", n),     32'(fin),     1);
    chk($sformatf("n%0d fin valido", n), 32'(valido), 0);
    chk($sformatf("n%0d fin ocupado", n), 32'(ocupado), 1);
    chk($sformatf("n%0d fin indice", n),  32'(indice_mascara), 0);
    tick();
    chk_reposo($sformatf("n%0d after", n));
    acepta = 1'b0;
  endtask

  initial begin
    int exp_idx;
    int c;
    logic tr;
    reset = 1'b1; cargar_config = 1'b0; tamano_entrada = '0; inicio = 1'b0; acepta = 1'b0;
    #12;
    chk_reposo("reset");
    chk("reset size",  32'(tamano_mascara), 3);
    chk("reset error", 32'(error_config),   0);
    chk("reset ultimo", 32'(ultimo),        0);
    reset = 1'b0;
    tick();

    // 1: default 3x3 sweep
    barrido(3);

    // 2: N=5
    cargar(5);
    chk("size5", 32'(tamano_mascara), 5);
    barrido(5);

    // 3: backpressure on 3x3
    cargar(3);
    inicio = 1'b1; acepta = 1'b0;
    tick();
    inicio = 1'b0;
    exp_idx = 0; c = 0;
    while (exp_idx < 9 && c < 100) begin
      chk($sformatf("bp c%0d indice", c), 32'(indice_mascara), exp_idx);
      chk($sformatf("bp c%0d fila", c),   32'(fila),    exp_idx / 3);
      chk($sformatf("bp c%0d col", c),    32'(columna), exp_idx % 3);
      chk($sformatf("bp c%0d valido", c), 32'(valido),  1);
      tr = (c % 3 == 0);
      acepta = tr;
      // Config and start requests during a sweep must be ignored.
      cargar_config = (c == 1); tamano_entrada = 4'd6; inicio = (c == 2);
      tick();
      cargar_config = 1'b0; inicio = 1'b0;
      if (tr) exp_idx++;
      c++;
    end
    chk("bp bound", 32'(exp_idx), 9);
    chk("bp fin", 32'(fin), 1);
    chk("bp size kept", 32'(tamano_mascara), 3);
    acepta = 1'b0;
    tick();
    chk_reposo("bp after");

    // 4: configuration limits (2^6 = 64)
    cargar(0);
    chk("cfg0 err",  32'(error_config),   1);
    chk("cfg0 size", 32'(tamano_mascara), 3);
    cargar(15);
    chk("cfg15 err",  32'(error_config),   1);
    chk("cfg15 size", 32'(tamano_mascara), 3);
    cargar(7);
    chk("cfg7 err",  32'(error_config),   0);
    chk("cfg7 size", 32'(tamano_mascara), 7);
    cargar(9);
    chk("cfg9 err",  32'(error_config),   1);
    chk("cfg9 size", 32'(tamano_mascara), 7);
    cargar(8);
    chk("cfg8 err",  32'(error_config),   0);
    chk("cfg8 size", 32'(tamano_mascara), 8);

    // 5: N=1, then config+inicio together
    cargar(1);
    barrido(1);
    cargar_config = 1'b1; inicio = 1'b1; tamano_entrada = 4'd3;
    tick();
    cargar_config = 1'b0; inicio = 1'b0;
    chk("cfg+inicio size",    32'(tamano_mascara), 3);
    chk("cfg+inicio ocupado", 32'(ocupado), 0);
    chk("cfg+inicio valido",  32'(valido),  0);
    tick();
    chk("cfg+inicio ocupado2", 32'(ocupado), 0);

    // 6: async reset mid-sweep at index 4
    inicio = 1'b1; acepta = 1'b1;
    tick();
    inicio = 1'b0;
    repeat (4) tick();
    chk("pre-rst indice", 32'(indice_mascara), 4);
    acepta = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk_reposo("async rst");
    chk("async rst fila", 32'(fila), 0);
    chk("async rst col",  32'(columna), 0);
    chk("async rst size", 32'(tamano_mascara), 3);
    reset = 1'b0;
    tick();
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
    chk("restart valido", 32'(valido), 1);
    chk("restart indice", 32'(indice_mascara), 0);
    chk("restart fila",   32'(fila), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
